// File: rtl/input_debouncer.sv
// input_debouncer
// Conditions a raw, possibly bouncing single-bit input into a clean level
// synchronous to clk. The input passes through a two-flop synchroniser.
// A four-state FSM then accepts a new level only after STABLE_CYCLES
// consecutive synchronised samples at that level. Registered one-cycle
// rise/fall strobes mark each accepted change.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic y,
  output logic rise,
  output logic fall
);

  // FSM encoding
  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  // Counter value on the final qualifying sample of a new level
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only sync2 is allowed to reach the FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse sync1/sync2
    // into a single flop.
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= d_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: count consecutive samples at the opposite level, commit on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      y     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // Strobes default low; they are set only on the committing edge
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            // Excursion too short: drop it without a strobe
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            y     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            y     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
// Directed scenarios followed by randomized bursts. Every cycle is compared
// against a run-length reference model. In that model, y flips once the
// synchronised input has differed from y for N consecutive samples.
module tb_input_debouncer;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic d_raw;
  logic y;
  logic rise;
  logic fall;

  int checks;
  int errors;
  int edge_no;
  int rise_cnt;
  int fall_cnt;
  int last_rise_edge;

  // Reference model state
  logic m_s1, m_s2, m_y, m_rise, m_fall;
  int   m_run;

  input_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_raw (d_raw),
    .y     (y),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare outputs 1 ns later
  task step(input logic d, input logic r);
    d_raw = d;
    rst   = r;
    @(posedge clk);
    edge_no++;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_y = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s2 != m_y) begin
        m_run++;
        if (m_run == N) begin
          m_y    = ~m_y;
          m_rise = m_y;
          m_fall = ~m_y;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = d;
    end
    #1;
    check("y", y, m_y);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    if (rise === 1'b1) begin
      rise_cnt++;
      last_rise_edge = edge_no;
    end
    if (fall === 1'b1) fall_cnt++;
  endtask

  // Hold d until y reaches target (bounded); n = edges taken
  task automatic wait_y(input logic target, input logic d, output int n);
    n = 0;
    while (n < 20 && y !== target) begin
      step(d, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n, rc0, fc0, e0;
    logic pat [9];
    checks = 0; errors = 0; edge_no = 0;
    rise_cnt = 0; fall_cnt = 0; last_rise_edge = 0;
    rst = 1'b1;
    d_raw = 1'b0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held 3 cycles with d_raw high, then release
    repeat (3) step(1'b1, 1'b1);
    check("reset_y", y, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    wait_y(1'b1, 1'b1, n);
    check("reset_release_latency", n, N + 2);
    check("reset_release_rise", rise, 1);
    step(1'b1, 1'b0);
    check("reset_release_rise_one_cycle", rise, 0);

    // Clean fall
    repeat (3) step(1'b1, 1'b0);
    rc0 = rise_cnt; fc0 = fall_cnt;
    wait_y(1'b0, 1'b0, n);
    check("fall_latency", n, N + 2);
    check("fall_strobe", fall, 1);
    repeat (4) step(1'b0, 1'b0);
    check("fall_single_pulse", fall_cnt - fc0, 1);
    check("fall_no_rise", rise_cnt - rc0, 0);

    // Clean rise
    rc0 = rise_cnt; fc0 = fall_cnt;
    wait_y(1'b1, 1'b1, n);
    check("rise_latency", n, N + 2);
    check("rise_strobe", rise, 1);
    repeat (4) step(1'b1, 1'b0);
    check("rise_single_pulse", rise_cnt - rc0, 1);
    check("rise_no_fall", fall_cnt - fc0, 0);

    // Back to low, then a pulse one sample short of the window
    repeat (10) step(1'b0, 1'b0);
    check("low_before_glitch", y, 0);
    rc0 = rise_cnt;
    repeat (N - 1) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check("glitch_rejected_y", y, 0);
    check("glitch_no_rise", rise_cnt - rc0, 0);
    check("glitch_cnt_cleared", dut.cnt, 0);

    // Pulse of exactly the window length is accepted
    rc0 = rise_cnt;
    repeat (N) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check("exact_pulse_rise", rise_cnt - rc0, 1);
    check("exact_pulse_y", y, 1);
    repeat (10) step(1'b0, 1'b0);
    check("exact_pulse_back_low", y, 0);

    // Bounce burst, then hold high
    rc0 = rise_cnt;
    e0  = edge_no;
    for (int i = 0; i < 9; i++) step(pat[i], 1'b0);
    repeat (8) step(1'b1, 1'b0);
    check("bounce_single_rise", rise_cnt - rc0, 1);
    // Final stable run starts at pattern index 5 (edge e0+6); y rises N+2 edges in
    check("bounce_rise_edge", last_rise_edge - e0, 5 + N + 2);

    // Reset in WAIT_LOW with cnt=2
    repeat (4) step(1'b0, 1'b0);
    check("mid_wait_cnt", dut.cnt, 2);
    check("mid_wait_y", y, 1);
    step(1'b0, 1'b1);
    check("mid_reset_y", y, 0);
    check("mid_reset_fall", fall, 0);
    check("mid_reset_cnt", dut.cnt, 0);
    rc0 = rise_cnt; fc0 = fall_cnt;
    repeat (10) step(1'b0, 1'b0);
    check("post_reset_no_fall", fall_cnt - fc0, 0);
    check("post_reset_no_rise", rise_cnt - rc0, 0);

    // Randomized runs of random length, with occasional resets
    for (int k = 0; k < 200; k++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * N);
      for (int j = 0; j < len; j++)
        step(v, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
